rs_station: RTL and testbench
=============================

Name: rs_station

Overview:
- Parametrised reservation station for the Tomasulo back end. Replaces the fixed single-purpose RS1/RS2 stations.
- Accepts one dispatched instruction per cycle from decode. Snoops NUM_CDB result broadcasts (ROB/ALU/memory) to wake waiting operands.
- Issues the oldest entry whose operands are both valid to its functional unit using a valid/ready handshake.
- One instance per unit class: arith/branch, store, load.

Parameters:
- DEPTH, 4, number of entries (2..16)
- DATA_W, 32, operand data width
- TAG_W, 4, ROB tag width
- NUM_CDB, 2, number of result broadcast ports
- CTRL_W, 16, opaque payload width (ALU control, writereg, flags, imm index, etc.), carried unmodified

Ports:
- CLK  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  decode presents an instruction
- alloc_ready  out  1  station can accept this cycle
- alloc_tag  in  TAG_W  ROB tag of the instruction
- alloc_v1, alloc_v2  in  1 each  operand valid; if 0, low TAG_W bits of alloc_dN hold the producer tag
- alloc_d1, alloc_d2  in  DATA_W each  operand value or producer tag
- alloc_ctrl  in  CTRL_W  payload
- cdb_valid  in  NUM_CDB  per-port broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W  packed, port k at [k*TAG_W +: TAG_W]
- cdb_data  in  NUM_CDB*DATA_W  packed, same ordering
- flush  in  1  ROB mispredict flush
- issue_valid  out  1  selected entry presented
- issue_ready  in  1  functional unit accepts
- issue_tag  out  TAG_W  tag of issued entry
- issue_d1, issue_d2  out  DATA_W  operand values
- issue_ctrl  out  CTRL_W  payload
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Each entry holds: busy, tag, v1, d1, v2, d2, ctrl, and an age rank. Age may be implemented as an age matrix or a sequence counter; the result must be strict allocation order.
- Reset (reset=1 at an edge): all busy=0, count=0. During and after reset: alloc_ready=1, issue_valid=0, and issue_tag/d1/d2/ctrl drive 0. Reset has priority over flush, alloc, issue and CDB.
- alloc_ready = (count < DEPTH) && !flush. It is registered-state based. A slot freed by a same-cycle issue is not reusable until the next cycle.
- Allocation fires on alloc_valid && alloc_ready:
  - The entry is written into the lowest-index free slot and becomes youngest.
  - Allocation-cycle bypass: if alloc_vN=0 and some cdb_valid[k] has cdb_tag[k] == alloc_dN[TAG_W-1:0], the entry stores cdb_data[k] with vN=1.
- Wakeup: every edge, each busy entry operand with vN=0 compares its tag against all valid CDB ports. On a match it captures the data and sets vN=1. If several ports match, the lowest k wins.
- Ready = busy && v1 && v2, evaluated on registered state only. A CDB capture makes the entry issue-eligible the following cycle; there is no wakeup-to-issue bypass.
- Select: issue_valid=1 iff any entry is ready. The oldest ready entry drives issue_* combinationally from registered state. If no entry is ready, issue_* drive 0.
- Issue fires on issue_valid && issue_ready: the selected entry's busy clears at the edge. At most one issue per cycle. If issue_ready=0, the same entry stays selected unless an older entry becomes ready, which is allowed to preempt.
- count next = count + alloc_fire − issue_fire. Simultaneous allocation and issue leaves count unchanged.
- Flush (flush=1 at an edge, reset=0): all busy clear and count=0. alloc_ready=0 that cycle. Allocation and issue are not performed even if handshakes appear asserted. The unit must ignore an issue_valid shown during a flush cycle.
- Full: count==DEPTH gives alloc_ready=0. Decode holds alloc_* stable. An issue that cycle frees space for the next cycle.
- Entries never reorder. Age ranks are preserved across frees, and a freed slot is reused as youngest.
- Payload (ctrl, tag) is never modified after allocation.

Test Plan:
- Reset then alloc tag=3, v1=v2=1, d1=5, d2=7, issue_ready=1 → next cycle issue_valid=1, issue_tag=3, d1=5, d2=7; the cycle after, count=0.
- Alloc tag=2, v1=0, d1=9 (waits on tag 9), v2=1. Two cycles later cdb_valid=01, cdb_tag[0]=9, data=0xAA → issue_valid rises one cycle after the broadcast with issue_d1=0xAA.
- Alloc tags 1, 2, 3 all ready, issue_ready=0 for 3 cycles then 1 → issue order is 1, 2, 3. If tag 1 waits and 2, 3 are ready, 2 issues first.
- DEPTH=4, fill with non-ready entries → alloc_ready=0 at count=4. Wake one entry and issue it → alloc_ready=1 on the next cycle, not the same cycle.
- Alloc with v2=0 tag 6 while cdb port 1 broadcasts tag 6, data 0x55 → entry stored ready and issues next cycle with d2=0x55. Both CDB ports broadcasting tag 6 (0x11 on port 0, 0x22 on port 1) → d2=0x11.
- Three entries busy, flush=1 with alloc_valid=1 → count=0 next cycle, issue_valid=0, no entry allocated. reset asserted mid-fill gives the same cleared state and outputs 0.

Source files
------------

// File: rtl/rs_station.sv
// Parametrised Tomasulo reservation station: in-order age tracking, CDB wakeup with
// allocation-cycle bypass, and oldest-ready issue over a valid/ready handshake.
module rs_station #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned CTRL_W  = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [TAG_W-1:0]           alloc_tag,
  input  logic                       alloc_v1,
  input  logic                       alloc_v2,
  input  logic [DATA_W-1:0]          alloc_d1,
  input  logic [DATA_W-1:0]          alloc_d2,
  input  logic [CTRL_W-1:0]          alloc_ctrl,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_data,
  input  logic                       flush,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [TAG_W-1:0]           issue_tag,
  output logic [DATA_W-1:0]          issue_d1,
  output logic [DATA_W-1:0]          issue_d2,
  output logic [CTRL_W-1:0]          issue_ctrl,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [DEPTH-1:0]  busy_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DEPTH-1:0]  v1_q, v2_q;
  logic [DATA_W-1:0] d1_q   [DEPTH];
  logic [DATA_W-1:0] d2_q   [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  // older_q[i][j] set means entry i was allocated before entry j (valid for busy pairs).
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [CntW-1:0]   count_q;

  logic [DEPTH-1:0]  rdy;
  logic              sel_valid, free_found, alloc_fire, issue_fire, oldest;
  logic [IdxW-1:0]   sel_idx, free_idx;
  logic [DATA_W:0]   byp1, byp2;
  logic [DATA_W:0]   wk1 [DEPTH];
  logic [DATA_W:0]   wk2 [DEPTH];

  // Returns {hit, data}; scanning downward lets the lowest-numbered port win.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]          t,
    input logic [NUM_CDB-1:0]        vld,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] data
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (vld[k] && tags[k*TAG_W +: TAG_W] == t) r = {1'b1, data[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  always_comb begin
    byp1 = cdb_lookup(alloc_d1[TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
    byp2 = cdb_lookup(alloc_d2[TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = cdb_lookup(d1_q[i][TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
      wk2[i] = cdb_lookup(d2_q[i][TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
    end
  end

  always_comb begin
    rdy        = busy_q & v1_q & v2_q;
    sel_valid  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    oldest     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest = rdy[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && rdy[j] && !older_q[i][j]) oldest = 1'b0;
      end
      if (oldest) begin
        sel_valid = 1'b1;
        sel_idx   = IdxW'(i);
      end
      if (!free_found && !busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    alloc_ready = reset || ((count_q < DepthC) && !flush);
    issue_valid = sel_valid && !reset;
    issue_tag   = issue_valid ? tag_q[sel_idx]  : '0;
    issue_d1    = issue_valid ? d1_q[sel_idx]   : '0;
    issue_d2    = issue_valid ? d2_q[sel_idx]   : '0;
    issue_ctrl  = issue_valid ? ctrl_q[sel_idx] : '0;
    alloc_fire  = alloc_valid && alloc_ready && !reset;
    issue_fire  = issue_valid && issue_ready && !flush;
    count       = count_q;
  end

  always_ff @(posedge CLK) begin
    if (reset || flush) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && !v1_q[i] && wk1[i][DATA_W]) begin
          v1_q[i] <= 1'b1;
          d1_q[i] <= wk1[i][DATA_W-1:0];
        end
        if (busy_q[i] && !v2_q[i] && wk2[i][DATA_W]) begin
          v2_q[i] <= 1'b1;
          d2_q[i] <= wk2[i][DATA_W-1:0];
        end
      end
      if (issue_fire) busy_q[sel_idx] <= 1'b0;
      if (alloc_fire) begin
        busy_q[free_idx] <= 1'b1;
        tag_q[free_idx]  <= alloc_tag;
        ctrl_q[free_idx] <= alloc_ctrl;
        v1_q[free_idx]   <= alloc_v1 || byp1[DATA_W];
        v2_q[free_idx]   <= alloc_v2 || byp2[DATA_W];
        d1_q[free_idx]   <= (!alloc_v1 && byp1[DATA_W]) ? byp1[DATA_W-1:0] : alloc_d1;
        d2_q[free_idx]   <= (!alloc_v2 && byp2[DATA_W]) ? byp2[DATA_W-1:0] : alloc_d2;
        // New entry is younger than everything currently present.
        for (int j = 0; j < DEPTH; j++) begin
          older_q[j][free_idx] <= 1'b1;
          older_q[free_idx][j] <= 1'b0;
        end
      end
      count_q <= count_q + CntW'(alloc_fire) - CntW'(issue_fire);
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: allocation, wakeup, bypass, age ordering, full, flush, reset.
module tb_rs_station;

  logic        CLK;
  logic        reset;
  logic        alloc_valid, alloc_ready;
  logic [3:0]  alloc_tag;
  logic        alloc_v1, alloc_v2;
  logic [31:0] alloc_d1, alloc_d2;
  logic [15:0] alloc_ctrl;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        flush;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_tag;
  logic [31:0] issue_d1, issue_d2;
  logic [15:0] issue_ctrl;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  rs_station dut (
    .CLK(CLK), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_v1(alloc_v1), .alloc_v2(alloc_v2), .alloc_d1(alloc_d1), .alloc_d2(alloc_d2),
    .alloc_ctrl(alloc_ctrl),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .issue_d1(issue_d1), .issue_d2(issue_d2), .issue_ctrl(issue_ctrl),
    .count(count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge CLK);
    #1;
  endtask

  task automatic alloc(input logic [3:0] t, input logic v1, input logic [31:0] d1,
                       input logic v2, input logic [31:0] d2);
    alloc_valid = 1'b1;
    alloc_tag   = t;
    alloc_v1    = v1;
    alloc_d1    = d1;
    alloc_v2    = v2;
    alloc_d2    = d2;
    alloc_ctrl  = 16'hC000 | 16'(t);
  endtask

  task automatic cdb(input logic [1:0] vld, input logic [3:0] t0, input logic [31:0] x0,
                     input logic [3:0] t1, input logic [31:0] x1);
    cdb_valid = vld;
    cdb_tag   = {t1, t0};
    cdb_data  = {x1, x0};
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; issue_ready = 1'b0; alloc_valid = 1'b0;
    alloc_tag = '0; alloc_v1 = 1'b0; alloc_v2 = 1'b0; alloc_d1 = '0; alloc_d2 = '0;
    alloc_ctrl = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    #1;
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_issue_valid", issue_valid, 0);
    clk1(); clk1();
    reset = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_issue_tag", issue_tag, 0);

    // Simple ready instruction issues the cycle after allocation.
    alloc(3, 1, 5, 1, 7); issue_ready = 1'b1;
    clk1(); alloc_valid = 1'b0;
    check("t1_valid", issue_valid, 1);
    check("t1_tag", issue_tag, 3);
    check("t1_d1", issue_d1, 5);
    check("t1_d2", issue_d2, 7);
    check("t1_ctrl", issue_ctrl, 16'hC003);
    check("t1_count1", count, 1);
    clk1();
    check("t1_count0", count, 0);
    check("t1_idle_d1", issue_d1, 0);

    // Wakeup through CDB port 0, visible one cycle after the broadcast.
    alloc(2, 0, 9, 1, 32'h33);
    clk1(); alloc_valid = 1'b0;
    check("t2_wait_a", issue_valid, 0);
    clk1();
    cdb(2'b01, 9, 32'hAA, 0, 0); #1;
    check("t2_no_bypass", issue_valid, 0);
    clk1(); cdb(0, 0, 0, 0, 0);
    check("t2_valid", issue_valid, 1);
    check("t2_d1", issue_d1, 32'hAA);
    check("t2_d2", issue_d2, 32'h33);
    clk1();
    check("t2_count", count, 0);

    // Age order with the unit stalled.
    issue_ready = 1'b0;
    alloc(1, 1, 1, 1, 1); clk1();
    alloc(2, 1, 2, 1, 2); clk1();
    alloc(3, 1, 3, 1, 3); clk1(); alloc_valid = 1'b0;
    check("t3_count", count, 3);
    check("t3_hold_a", issue_tag, 1);
    clk1();
    check("t3_hold_b", issue_tag, 1);
    issue_ready = 1'b1; #1;
    check("t3_first", issue_tag, 1);
    clk1(); check("t3_second", issue_tag, 2);
    clk1(); check("t3_third", issue_tag, 3);
    clk1(); check("t3_empty", issue_valid, 0);

    // Older waiting entry preempts the selection once it wakes.
    issue_ready = 1'b0;
    alloc(1, 0, 14, 1, 1); clk1();
    alloc(2, 1, 2, 1, 2);  clk1();
    alloc(3, 1, 3, 1, 3);  clk1(); alloc_valid = 1'b0;
    check("t3p_young_first", issue_tag, 2);
    cdb(2'b01, 14, 32'h77, 0, 0);
    clk1(); cdb(0, 0, 0, 0, 0);
    check("t3p_preempt", issue_tag, 1);
    check("t3p_d1", issue_d1, 32'h77);
    issue_ready = 1'b1;
    clk1(); check("t3p_then2", issue_tag, 2);
    clk1(); check("t3p_then3", issue_tag, 3);
    clk1(); check("t3p_count", count, 0);

    // Fill with waiting entries, then free one slot by issue.
    issue_ready = 1'b0;
    alloc(4, 0, 8, 1, 0);  clk1();
    alloc(5, 0, 9, 1, 0);  clk1();
    alloc(6, 0, 10, 1, 0); clk1();
    alloc(7, 0, 11, 1, 0); clk1();
    alloc(12, 1, 1, 1, 2); #1;
    check("t4_full_count", count, 4);
    check("t4_full_ready", alloc_ready, 0);
    clk1();
    check("t4_held_count", count, 4);
    cdb(2'b01, 8, 32'h100, 0, 0);
    clk1(); cdb(0, 0, 0, 0, 0);
    check("t4_wake_tag", issue_tag, 4);
    check("t4_wake_d1", issue_d1, 32'h100);
    issue_ready = 1'b1; #1;
    check("t4_same_cycle", alloc_ready, 0);
    clk1();
    check("t4_after_issue_count", count, 3);
    check("t4_after_issue_ready", alloc_ready, 1);
    clk1(); alloc_valid = 1'b0;
    check("t4_refill_count", count, 4);
    check("t4_reuse_tag", issue_tag, 12);
    clk1();
    check("t4_drain_count", count, 3);
    check("t4_drain_valid", issue_valid, 0);

    // Flush beats a simultaneous allocation.
    flush = 1'b1; alloc(13, 1, 1, 1, 1); #1;
    check("t6_flush_ready", alloc_ready, 0);
    clk1(); flush = 1'b0; alloc_valid = 1'b0;
    check("t6_flush_count", count, 0);
    check("t6_flush_valid", issue_valid, 0);
    cdb(2'b01, 9, 32'h5, 0, 0);
    clk1(); cdb(0, 0, 0, 0, 0);
    check("t6_no_ghost", issue_valid, 0);
    check("t6_count_stay", count, 0);

    // Allocation-cycle bypass, port 1, then both ports with port 0 winning.
    alloc(6, 1, 32'h44, 0, 6); cdb(2'b10, 0, 0, 6, 32'h55);
    clk1(); alloc_valid = 1'b0; cdb(0, 0, 0, 0, 0);
    check("t5_valid", issue_valid, 1);
    check("t5_d2", issue_d2, 32'h55);
    check("t5_d1", issue_d1, 32'h44);
    clk1();
    alloc(6, 1, 32'h44, 0, 6); cdb(2'b11, 6, 32'h11, 6, 32'h22);
    clk1(); alloc_valid = 1'b0; cdb(0, 0, 0, 0, 0);
    check("t5_prio_d2", issue_d2, 32'h11);
    clk1();
    check("t5_count", count, 0);

    // Reset in the middle of filling.
    issue_ready = 1'b0;
    alloc(1, 1, 1, 1, 1); clk1();
    alloc(2, 1, 2, 1, 2); clk1();
    reset = 1'b1; alloc(3, 1, 3, 1, 3); #1;
    check("t7_rst_valid", issue_valid, 0);
    check("t7_rst_tag", issue_tag, 0);
    check("t7_rst_ready", alloc_ready, 1);
    clk1(); reset = 1'b0; alloc_valid = 1'b0; #1;
    check("t7_count", count, 0);
    check("t7_valid", issue_valid, 0);
    check("t7_d1", issue_d1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
